sisc_seq_ctrl: RTL and testbench

- Multicycle control sequencer for the SISC datapath; sits directly upstream of the 16-bit write-back mux.
- Generates the mux's 2-bit select plus all per-cycle datapath strobes: IR load, PC update, ALU enable, memory read/write, register-file write.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready handshake to memory.
- Halts on the HALT opcode; optionally halts on a memory timeout.

---
 rtl/sisc_ctrl_pkg.sv | 33 +++
 rtl/sisc_seq_ctrl_if.sv | 38 +++
 rtl/sisc_mem_wait_timer.sv | 28 ++
 rtl/sisc_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_sisc_seq_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sisc_ctrl_pkg.sv
// Shared definitions for the SISC control sequencer: state encoding,
// opcode values and write-back mux select codes.
package sisc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ALU    = 4'b0001;
  localparam logic [3:0] OP_LOAD   = 4'b0010;
  localparam logic [3:0] OP_LDI    = 4'b0011;
  localparam logic [3:0] OP_STORE  = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b0101;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  function automatic logic isLegalOp(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ALU, OP_LOAD, OP_LDI, OP_STORE, OP_BRANCH, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sisc_seq_ctrl_if.sv
// Control bundle between the SISC sequencer (master) and the datapath (slave).
// SISC_MEM_TIMEOUT_EN adds the sticky mem_timeout flag.
interface sisc_seq_ctrl_if;
  logic [3:0] opcode;
  logic       cond_met;
  logic       mem_ready;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       alu_en;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] wb_sel;
  logic       rf_we;
  logic       halted;
  logic       illegal_op;
`ifdef SISC_MEM_TIMEOUT_EN
  logic       mem_timeout;
`endif

  modport master (
    input  opcode, cond_met, mem_ready,
    output ir_load, pc_inc, pc_load, alu_en, mem_rd, mem_wr,
           wb_sel, rf_we, halted, illegal_op
`ifdef SISC_MEM_TIMEOUT_EN
    , output mem_timeout
`endif
  );

  modport slave (
    output opcode, cond_met, mem_ready,
    input  ir_load, pc_inc, pc_load, alu_en, mem_rd, mem_wr,
           wb_sel, rf_we, halted, illegal_op
`ifdef SISC_MEM_TIMEOUT_EN
    , input mem_timeout
`endif
  );
endinterface

// File: rtl/sisc_mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without mem_ready and
// flags the cycle in which the wait reaches LIMIT.
module sisc_mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting_i,
  input  logic ready_i,
  output logic expired_o
);

  logic [7:0] countQ;
  logic [7:0] countD;

  // Any cycle without an outstanding unanswered request restarts the count.
  always_comb begin
    countD = (waiting_i && !ready_i) ? countQ + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) countQ <= 8'd0;
    else     countQ <= countD;
  end

  assign expired_o = waiting_i && !ready_i && (countQ == 8'(LIMIT - 1));

endmodule

// File: rtl/sisc_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the SISC datapath strobes.
// Optional memory-wait timeout enabled by defining SISC_MEM_TIMEOUT_EN.
module sisc_seq_ctrl
  import sisc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  sisc_seq_ctrl_if.master    bus
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_badTimeout
    $error("MEM_TIMEOUT must be in 1..255");
  end

  state_e     stateQ, stateD;
  logic [3:0] opQ, opD;
  logic [1:0] wbSelQ, wbSelD;
  logic       illegalQ, illegalD;
  logic       memRdQ, memRdD;
  logic       memWrQ, memWrD;
  logic       aluEnQ, aluEnD;
  logic       rfWeQ, rfWeD;
  logic       haltedQ, haltedD;
  logic       fetchDone;
  logic       timeoutHit;

`ifdef SISC_MEM_TIMEOUT_EN
  logic       timeoutQ;

  sisc_mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_waitTimer (
    .clk       (clk),
    .rst       (rst),
    .waiting_i (memRdQ || memWrQ),
    .ready_i   (bus.mem_ready),
    .expired_o (timeoutHit)
  );

  assign bus.mem_timeout = timeoutQ;
`else
  assign timeoutHit = 1'b0;
`endif

  // memRdQ is still low in the first cycle after reset, so no fetch completes there.
  assign fetchDone = (stateQ == ST_FETCH) && memRdQ && bus.mem_ready;

  always_comb begin
    stateD   = stateQ;
    opD      = opQ;
    wbSelD   = wbSelQ;
    illegalD = illegalQ;

    case (stateQ)
      ST_FETCH: begin
        if (fetchDone)       stateD = ST_DECODE;
        else if (timeoutHit) stateD = ST_HALT;
      end
      ST_DECODE: begin
        opD = bus.opcode;
        case (bus.opcode)
          OP_ALU:  wbSelD = WB_ALU;
          OP_LOAD: wbSelD = WB_MEM;
          OP_LDI:  wbSelD = WB_IMM;
          default: wbSelD = wbSelQ;
        endcase
        if (!isLegalOp(bus.opcode)) illegalD = 1'b1;
        stateD = (bus.opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        case (opQ)
          OP_ALU, OP_LDI:    stateD = ST_WB;
          OP_LOAD, OP_STORE: stateD = ST_MEM;
          default:           stateD = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready)   stateD = (opQ == OP_LOAD) ? ST_WB : ST_FETCH;
        else if (timeoutHit) stateD = ST_HALT;
      end
      ST_WB:   stateD = ST_FETCH;
      ST_HALT: stateD = ST_HALT;
      default: stateD = ST_FETCH;
    endcase

    // Strobes are registered against the state being entered.
    memRdD  = (stateD == ST_FETCH) || ((stateD == ST_MEM) && (opD == OP_LOAD));
    memWrD  = (stateD == ST_MEM) && (opD == OP_STORE);
    aluEnD  = (stateD == ST_EXEC) && (opD == OP_ALU);
    rfWeD   = (stateD == ST_WB);
    haltedD = (stateD == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= ST_FETCH;
      opQ      <= OP_NOP;
      wbSelQ   <= WB_ALU;
      illegalQ <= 1'b0;
      memRdQ   <= 1'b0;
      memWrQ   <= 1'b0;
      aluEnQ   <= 1'b0;
      rfWeQ    <= 1'b0;
      haltedQ  <= 1'b0;
`ifdef SISC_MEM_TIMEOUT_EN
      timeoutQ <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      opQ      <= opD;
      wbSelQ   <= wbSelD;
      illegalQ <= illegalD;
      memRdQ   <= memRdD;
      memWrQ   <= memWrD;
      aluEnQ   <= aluEnD;
      rfWeQ    <= rfWeD;
      haltedQ  <= haltedD;
`ifdef SISC_MEM_TIMEOUT_EN
      timeoutQ <= timeoutQ || timeoutHit;
`endif
    end
  end

  assign bus.ir_load    = fetchDone;
  assign bus.pc_inc     = fetchDone;
  assign bus.pc_load    = (stateQ == ST_EXEC) && (opQ == OP_BRANCH) && bus.cond_met;
  assign bus.alu_en     = aluEnQ;
  assign bus.mem_rd     = memRdQ;
  assign bus.mem_wr     = memWrQ;
  assign bus.wb_sel     = wbSelQ;
  assign bus.rf_we      = rfWeQ;
  assign bus.halted     = haltedQ;
  assign bus.illegal_op = illegalQ;

endmodule

// File: tb/tb_sisc_seq_ctrl.sv
// Directed self-checking bench for sisc_seq_ctrl; expected strobe vectors are
// hand-derived per cycle. Timeout checks compile in with SISC_MEM_TIMEOUT_EN.
module tb_sisc_seq_ctrl;

  logic clk;
  logic rst;
  int   vectorCount;
  int   errorCount;

  sisc_seq_ctrl_if busIf ();

  sisc_seq_ctrl #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs strobes as {ir_load, pc_inc, pc_load, alu_en, mem_rd, mem_wr, wb_sel, rf_we, halted, illegal_op}.
  function automatic logic [10:0] expVec(input logic ir, input logic pci, input logic pcl,
                                         input logic alu, input logic rd, input logic wr,
                                         input logic [1:0] wb, input logic rf,
                                         input logic h, input logic ill);
    return {ir, pci, pcl, alu, rd, wr, wb, rf, h, ill};
  endfunction

  function automatic logic [10:0] obsVec();
    return {busIf.ir_load, busIf.pc_inc, busIf.pc_load, busIf.alu_en, busIf.mem_rd,
            busIf.mem_wr, busIf.wb_sel, busIf.rf_we, busIf.halted, busIf.illegal_op};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic cond, input logic rdy);
    @(negedge clk);
    busIf.opcode    = op;
    busIf.cond_met  = cond;
    busIf.mem_ready = rdy;
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic cond,
                      input logic rdy, input logic [10:0] expected);
    applyStimulus(op, cond, rdy);
    checkOutput(tag, 16'(obsVec()), 16'(expected));
  endtask

  initial begin
    vectorCount     = 0;
    errorCount      = 0;
    rst             = 1'b1;
    busIf.opcode    = 4'h1;
    busIf.cond_met  = 1'b1;
    busIf.mem_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset", 16'(obsVec()), 16'(expVec(0,0,0,0,0,0,2'b00,0,0,0)));
    rst = 1'b0;

    // ALU, zero-wait memory
    step("alu_c0", 4'h1, 0, 1, expVec(1,1,0,0,1,0,2'b00,0,0,0));
    step("alu_c1", 4'h1, 0, 1, expVec(0,0,0,0,0,0,2'b00,0,0,0));
    step("alu_c2", 4'h1, 0, 1, expVec(0,0,0,1,0,0,2'b00,0,0,0));
    step("alu_c3", 4'h1, 0, 1, expVec(0,0,0,0,0,0,2'b00,1,0,0));

    // LOAD with three wait cycles in MEM
    step("ld_c0", 4'h2, 0, 1, expVec(1,1,0,0,1,0,2'b00,0,0,0));
    step("ld_c1", 4'h2, 0, 1, expVec(0,0,0,0,0,0,2'b00,0,0,0));
    step("ld_c2", 4'h2, 0, 1, expVec(0,0,0,0,0,0,2'b01,0,0,0));
    step("ld_c3", 4'h2, 0, 0, expVec(0,0,0,0,1,0,2'b01,0,0,0));
    step("ld_c4", 4'h2, 0, 0, expVec(0,0,0,0,1,0,2'b01,0,0,0));
    step("ld_c5", 4'h2, 0, 0, expVec(0,0,0,0,1,0,2'b01,0,0,0));
    step("ld_c6", 4'h2, 0, 1, expVec(0,0,0,0,1,0,2'b01,0,0,0));
    step("ld_c7", 4'h2, 0, 1, expVec(0,0,0,0,0,0,2'b01,1,0,0));

    // LDI then STORE
    step("ldi_c0", 4'h3, 0, 1, expVec(1,1,0,0,1,0,2'b01,0,0,0));
    step("ldi_c1", 4'h3, 0, 1, expVec(0,0,0,0,0,0,2'b01,0,0,0));
    step("ldi_c2", 4'h3, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("ldi_c3", 4'h3, 0, 1, expVec(0,0,0,0,0,0,2'b10,1,0,0));
    step("st_c0",  4'h4, 0, 1, expVec(1,1,0,0,1,0,2'b10,0,0,0));
    step("st_c1",  4'h4, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("st_c2",  4'h4, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("st_c3",  4'h4, 0, 1, expVec(0,0,0,0,0,1,2'b10,0,0,0));

    // BRANCH taken, then not taken
    step("br1_c0", 4'h5, 1, 1, expVec(1,1,0,0,1,0,2'b10,0,0,0));
    step("br1_c1", 4'h5, 1, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("br1_c2", 4'h5, 1, 1, expVec(0,0,1,0,0,0,2'b10,0,0,0));
    step("br0_c0", 4'h5, 0, 1, expVec(1,1,0,0,1,0,2'b10,0,0,0));
    step("br0_c1", 4'h5, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("br0_c2", 4'h5, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));

    // NOP with one fetch wait cycle
    step("nop_c0", 4'h0, 0, 0, expVec(0,0,0,0,1,0,2'b10,0,0,0));
    step("nop_c1", 4'h0, 0, 1, expVec(1,1,0,0,1,0,2'b10,0,0,0));
    step("nop_c2", 4'h0, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("nop_c3", 4'h0, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));

    // Illegal opcode, then HALT
    step("ill_c0", 4'hA, 0, 1, expVec(1,1,0,0,1,0,2'b10,0,0,0));
    step("ill_c1", 4'hA, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,0));
    step("ill_c2", 4'hA, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,1));
    step("hlt_c0", 4'hF, 0, 1, expVec(1,1,0,0,1,0,2'b10,0,0,1));
    step("hlt_c1", 4'hF, 0, 1, expVec(0,0,0,0,0,0,2'b10,0,0,1));
    step("hlt_c2", 4'h1, 1, 1, expVec(0,0,0,0,0,0,2'b10,0,1,1));
    step("hlt_c3", 4'h5, 1, 1, expVec(0,0,0,0,0,0,2'b10,0,1,1));
    step("hlt_c4", 4'h2, 1, 1, expVec(0,0,0,0,0,0,2'b10,0,1,1));

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("hlt_rst", 16'(obsVec()), 16'(expVec(0,0,0,0,0,0,2'b00,0,0,0)));
    @(negedge clk);
    rst = 1'b0;

    // STORE aborted by reset while waiting in MEM
    step("rs_c0", 4'h4, 0, 1, expVec(1,1,0,0,1,0,2'b00,0,0,0));
    step("rs_c1", 4'h4, 0, 1, expVec(0,0,0,0,0,0,2'b00,0,0,0));
    step("rs_c2", 4'h4, 0, 1, expVec(0,0,0,0,0,0,2'b00,0,0,0));
    step("rs_c3", 4'h4, 0, 0, expVec(0,0,0,0,0,1,2'b00,0,0,0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rs_abort", 16'(obsVec()), 16'(expVec(0,0,0,0,0,0,2'b00,0,0,0)));
    @(negedge clk);
    rst = 1'b0;
    step("rs_c4", 4'h0, 0, 0, expVec(0,0,0,0,1,0,2'b00,0,0,0));
    step("rs_c5", 4'h0, 0, 1, expVec(1,1,0,0,1,0,2'b00,0,0,0));

`ifdef SISC_MEM_TIMEOUT_EN
    @(negedge clk);
    rst = 1'b1;
    busIf.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("to_c0", 4'h0, 0, 0, expVec(0,0,0,0,1,0,2'b00,0,0,0));
    step("to_c1", 4'h0, 0, 0, expVec(0,0,0,0,1,0,2'b00,0,0,0));
    step("to_c2", 4'h0, 0, 0, expVec(0,0,0,0,1,0,2'b00,0,0,0));
    step("to_c3", 4'h0, 0, 0, expVec(0,0,0,0,1,0,2'b00,0,0,0));
    checkOutput("to_flag0", 16'(busIf.mem_timeout), 16'd0);
    step("to_c4", 4'h0, 0, 0, expVec(0,0,0,0,0,0,2'b00,0,1,0));
    checkOutput("to_flag1", 16'(busIf.mem_timeout), 16'd1);
    step("to_c5", 4'h0, 0, 1, expVec(0,0,0,0,0,0,2'b00,0,1,0));
    checkOutput("to_sticky", 16'(busIf.mem_timeout), 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
